sr_load_sequencer: RTL and testbench
====================================

SR_LOAD_SEQUENCER -- requirements
Module: sr_load_sequencer

Interface
REQ-001 SHALL have parameter SIZESRSTAT, default 88, static shift register length in bits.
REQ-002 SHALL have parameter SIZESRDYN, default 16, dynamic shift register length in bits.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port UC_DATA  input  1  serial data bit from microcontroller.
REQ-006 SHALL have port UC_VALID  input  1  UC_DATA valid this cycle; a bit transfers when UC_VALID and UC_READY are both high.
REQ-007 SHALL have port UC_READY  output  1  block accepts a serial bit this cycle.
REQ-008 SHALL have port STATLATCH  output  SIZESRSTAT  latched static word.
REQ-009 SHALL have port DYNLATCH  output  SIZESRDYN  latched dynamic word.
REQ-010 SHALL have port SELSTAT  output  1  static segment being shifted out.
REQ-011 SHALL have port SELDYN  output  1  dynamic segment being shifted out.
REQ-012 SHALL have port signal_out  output  1  serialized output bit.
REQ-013 SHALL have port ENFIN  output  1  one-cycle pulse at end of a full shift-out.
REQ-014 SHALL have port OVERRUN  output  1  sticky flag: UC_VALID high while UC_READY low.

Function
REQ-015 SHALL implement states IDLE, RX_STAT, RX_DYN, TX_STAT, TX_DYN, DONE.
REQ-016 IDLE: UC_READY=1; first accepted bit SHALL be static bit SIZESRSTAT-1 (MSB-first), state -> RX_STAT.
REQ-017 RX_STAT: SHALL accept bits into a shadow static shift register until SIZESRSTAT bits total accepted, then -> RX_DYN.
REQ-018 RX_DYN: SHALL accept SIZESRDYN bits MSB-first into shadow dynamic register; on accepting the last bit, STATLATCH and DYNLATCH SHALL load both shadows on that same edge, state -> TX_STAT.
REQ-019 Cycles with UC_VALID=0 in RX states SHALL hold the bit counter and shadows (gaps allowed, no timeout).
REQ-020 STATLATCH/DYNLATCH SHALL change only at the REQ-018 edge; a partial frame never alters them.
REQ-021 TX_STAT: SELSTAT=1, SELDYN=0 for exactly SIZESRSTAT cycles; signal_out = STATLATCH[SIZESRSTAT-1] on first cycle, descending to bit 0 on last.
REQ-022 TX_DYN: SELDYN=1, SELSTAT=0 for exactly SIZESRDYN cycles; signal_out = DYNLATCH MSB down to bit 0.
REQ-023 DONE: one cycle, ENFIN=1, SELSTAT=SELDYN=0, then -> IDLE.
REQ-024 SELSTAT and SELDYN SHALL never be high simultaneously; signal_out SHALL be 0 when neither is high.
REQ-025 signal_out, SELSTAT, SELDYN, ENFIN SHALL be registered outputs (no combinational path from inputs).
REQ-026 UC_READY SHALL be 1 in IDLE, RX_STAT, RX_DYN and 0 in TX_STAT, TX_DYN, DONE.
REQ-027 Latency: first TX_STAT cycle SHALL be the cycle after the last-bit-accept edge; ENFIN SHALL occur SIZESRSTAT+SIZESRDYN+1 cycles after that edge.
REQ-028 UC_VALID=1 while UC_READY=0 SHALL set OVERRUN (bit discarded, no state effect); OVERRUN cleared only by reset.
REQ-029 Bit counter SHALL be wide enough for max(SIZESRSTAT,SIZESRDYN) and SHALL reset to 0 on every state change; no wrap beyond segment length.

Reset
REQ-030 RST_N low SHALL asynchronously force IDLE, counters 0, shadows 0, STATLATCH=0, DYNLATCH=0, SELSTAT=0, SELDYN=0, signal_out=0, ENFIN=0, OVERRUN=0; UC_READY=1 after release.
REQ-031 Reset mid-receive or mid-transmit SHALL discard the partial frame/shift-out; no ENFIN is issued.

Verification
REQ-032 Send 104 contiguous bits = 88'hABCDEF123456789ABCDEF1 then 16'h1234 -> STATLATCH/DYNLATCH match next cycle; SELSTAT high 88 cycles then SELDYN 16; serial stream equals input; ENFIN pulse 105 cycles after last accept.
REQ-033 Same frame with random UC_VALID gaps -> identical latches and output stream, timing referenced to last accept.
REQ-034 UC_VALID held high through TX -> OVERRUN=1 from first TX cycle, latches unchanged, second frame accepted normally after DONE.
REQ-035 Assert RST_N low after 50 static bits, then send full frame 16'hFFFF dyn / all-zero static -> latches reflect only new frame, no stray ENFIN.
REQ-036 Reset pulse during TX_DYN cycle 5 -> all outputs 0 immediately, no ENFIN, UC_READY=1 after release.
REQ-037 Back-to-back frames (second frame starts first cycle of IDLE after DONE) -> two complete shift-outs, two ENFIN pulses, SELSTAT/SELDYN never overlap.

Source files
------------

// File: rtl/sr_load_sequencer.sv
// Serial frame loader: receives a static+dynamic word MSB-first from a microcontroller,
// latches both words at once, then shifts them back out with segment selects and an end pulse.
module sr_load_sequencer #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  UC_DATA,
    input  logic                  UC_VALID,
    output logic                  UC_READY,
    output logic [SIZESRSTAT-1:0] STATLATCH,
    output logic [SIZESRDYN-1:0]  DYNLATCH,
    output logic                  SELSTAT,
    output logic                  SELDYN,
    output logic                  signal_out,
    output logic                  ENFIN,
    output logic                  OVERRUN
);

    localparam int MAXLEN = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
    localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int SW     = $clog2(SIZESRSTAT);
    localparam int DW     = $clog2(SIZESRDYN);

    typedef enum logic [2:0] {IDLE, RX_STAT, RX_DYN, TX_STAT, TX_DYN, DONE} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [SIZESRSTAT-1:0]   stat_sh, stat_sh_nx, stat_nx;
    logic [SIZESRDYN-1:0]    dyn_sh, dyn_sh_nx, dyn_nx;
    logic [SW-1:0]           stat_idx;
    logic [DW-1:0]           dyn_idx;
    logic                    accept, ovr_q;
    logic                    sel_stat_nx, sel_dyn_nx, out_nx, enfin_nx;

    always_comb begin
        UC_READY = (state == IDLE) || (state == RX_STAT) || (state == RX_DYN);
        accept   = UC_VALID && UC_READY;
        OVERRUN  = ovr_q || (UC_VALID && !UC_READY);
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        stat_sh_nx = stat_sh;
        dyn_sh_nx  = dyn_sh;
        stat_nx    = STATLATCH;
        dyn_nx     = DYNLATCH;
        case (state)
            IDLE: if (accept) begin
                stat_sh_nx = {stat_sh[SIZESRSTAT-2:0], UC_DATA};
                cnt_nx     = CW'(1);
                state_nx   = RX_STAT;
            end
            RX_STAT: if (accept) begin
                stat_sh_nx = {stat_sh[SIZESRSTAT-2:0], UC_DATA};
                if (cnt == CW'(SIZESRSTAT - 1)) begin
                    state_nx = RX_DYN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RX_DYN: if (accept) begin
                dyn_sh_nx = {dyn_sh[SIZESRDYN-2:0], UC_DATA};
                if (cnt == CW'(SIZESRDYN - 1)) begin
                    state_nx = TX_STAT;
                    cnt_nx   = '0;
                    stat_nx  = stat_sh;
                    dyn_nx   = dyn_sh_nx;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            TX_STAT: begin
                if (cnt == CW'(SIZESRSTAT - 1)) begin
                    state_nx = TX_DYN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            TX_DYN: begin
                if (cnt == CW'(SIZESRDYN - 1)) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Outputs are decoded from the upcoming state/count so they register in step with it.
        stat_idx    = SW'(SIZESRSTAT - 1) - SW'(cnt_nx);
        dyn_idx     = DW'(SIZESRDYN - 1) - DW'(cnt_nx);
        sel_stat_nx = (state_nx == TX_STAT);
        sel_dyn_nx  = (state_nx == TX_DYN);
        enfin_nx    = (state_nx == DONE);
        out_nx      = 1'b0;
        if (sel_stat_nx)
            out_nx = stat_nx[stat_idx];
        else if (sel_dyn_nx)
            out_nx = dyn_nx[dyn_idx];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            cnt        <= '0;
            stat_sh    <= '0;
            dyn_sh     <= '0;
            STATLATCH  <= '0;
            DYNLATCH   <= '0;
            SELSTAT    <= 1'b0;
            SELDYN     <= 1'b0;
            signal_out <= 1'b0;
            ENFIN      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            stat_sh    <= stat_sh_nx;
            dyn_sh     <= dyn_sh_nx;
            STATLATCH  <= stat_nx;
            DYNLATCH   <= dyn_nx;
            SELSTAT    <= sel_stat_nx;
            SELDYN     <= sel_dyn_nx;
            signal_out <= out_nx;
            ENFIN      <= enfin_nx;
            ovr_q      <= OVERRUN;
        end
    end

endmodule

// File: tb/tb_sr_load_sequencer.sv
// Randomized bench for sr_load_sequencer: frames are modelled as one concatenated
// static+dynamic word whose bits must reappear MSB-first after the final accept.
module tb_sr_load_sequencer;

    localparam int S = 88;
    localparam int D = 16;
    localparam int N = S + D;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         UC_DATA;
    logic         UC_VALID;
    logic         UC_READY;
    logic [S-1:0] STATLATCH;
    logic [D-1:0] DYNLATCH;
    logic         SELSTAT;
    logic         SELDYN;
    logic         signal_out;
    logic         ENFIN;
    logic         OVERRUN;

    sr_load_sequencer #(.SIZESRSTAT(S), .SIZESRDYN(D)) dut (
        .CLK(CLK), .RST_N(RST_N), .UC_DATA(UC_DATA), .UC_VALID(UC_VALID),
        .UC_READY(UC_READY), .STATLATCH(STATLATCH), .DYNLATCH(DYNLATCH),
        .SELSTAT(SELSTAT), .SELDYN(SELDYN), .signal_out(signal_out),
        .ENFIN(ENFIN), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;
    int unsigned  enfin_seen = 0;
    int unsigned  exp_enfin = 0;
    logic [S-1:0] exp_stat = '0;
    logic [D-1:0] exp_dyn = '0;
    logic         exp_ovr = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (ENFIN === 1'b1) enfin_seen++;
        check("sel_overlap", {127'd0, SELSTAT & SELDYN}, '0);
        if (!SELSTAT && !SELDYN) check("out_idle_zero", {127'd0, signal_out}, '0);
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_selstat"}, {127'd0, SELSTAT}, '0);
        check({tag, "_seldyn"}, {127'd0, SELDYN}, '0);
        check({tag, "_out"}, {127'd0, signal_out}, '0);
        check({tag, "_enfin"}, {127'd0, ENFIN}, '0);
        check({tag, "_stat"}, {40'd0, STATLATCH}, '0);
        check({tag, "_dyn"}, {112'd0, DYNLATCH}, '0);
        check({tag, "_ovr"}, {127'd0, OVERRUN}, '0);
        check({tag, "_ready"}, {127'd0, UC_READY}, 128'd1);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        UC_VALID = 1'b0;
        #1;
        check_reset_outputs("rst");
        exp_stat = '0;
        exp_dyn = '0;
        exp_ovr = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Drive the first nbits of the frame; the last bit is accepted on the following posedge.
    task automatic send_bits(input logic [S-1:0] st, input logic [D-1:0] dy, input bit gaps, input int nbits);
        logic [N-1:0] sr;
        int g;
        sr = {st, dy};
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    @(negedge CLK);
                    UC_VALID = 1'b0;
                    UC_DATA = 1'($urandom);
                    check("latch_hold_stat", {40'd0, STATLATCH}, {40'd0, exp_stat});
                    check("latch_hold_dyn", {112'd0, DYNLATCH}, {112'd0, exp_dyn});
                end
            end
            @(negedge CLK);
            check("ready_rx", {127'd0, UC_READY}, 128'd1);
            UC_VALID = 1'b1;
            UC_DATA = sr[N-1];
            sr = sr << 1;
        end
    endtask

    task automatic check_tx(input logic [S-1:0] st, input logic [D-1:0] dy, input bit hold_valid, input int abort_at);
        logic [N-1:0] sr;
        logic exp_bit;
        sr = {st, dy};
        exp_stat = st;
        exp_dyn = dy;
        for (int k = 0; k <= N; k++) begin
            @(negedge CLK);
            if (hold_valid) begin
                UC_DATA = 1'($urandom);
                exp_ovr = 1'b1;
            end else if (k == 0) begin
                UC_VALID = 1'b0;
            end
            if (k == abort_at) begin
                RST_N = 1'b0;
                UC_VALID = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_stat = '0;
                exp_dyn = '0;
                exp_ovr = 1'b0;
                @(negedge CLK);
                RST_N = 1'b1;
                return;
            end
            exp_bit = (k < N) ? sr[N-1] : 1'b0;
            sr = sr << 1;
            check("selstat", {127'd0, SELSTAT}, {127'd0, k < S});
            check("seldyn", {127'd0, SELDYN}, {127'd0, (k >= S) && (k < N)});
            check("enfin", {127'd0, ENFIN}, {127'd0, k == N});
            check("serial", {127'd0, signal_out}, {127'd0, exp_bit});
            check("ready_tx", {127'd0, UC_READY}, '0);
            check("statlatch", {40'd0, STATLATCH}, {40'd0, exp_stat});
            check("dynlatch", {112'd0, DYNLATCH}, {112'd0, exp_dyn});
            if (hold_valid || k > 0) check("overrun", {127'd0, OVERRUN}, {127'd0, exp_ovr});
            if (k == N) begin
                exp_enfin++;
                if (hold_valid) UC_VALID = 1'b0;
            end
        end
    endtask

    task automatic rand_frame(output logic [S-1:0] st, output logic [D-1:0] dy);
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        st = w[S-1:0];
        dy = D'($urandom);
    endtask

    task automatic idle_check(input int cycles);
        repeat (cycles) begin
            @(negedge CLK);
            check("idle_sel", {125'd0, SELSTAT, SELDYN, ENFIN}, '0);
            check("idle_ready", {127'd0, UC_READY}, 128'd1);
        end
        check("enfin_count", {96'd0, enfin_seen}, {96'd0, exp_enfin});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [S-1:0] st, st2;
        logic [D-1:0] dy, dy2;
        UC_VALID = 1'b0;
        UC_DATA = 1'b0;
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        idle_check(2);

        // Reference frame, contiguous then with random gaps
        send_bits(88'hABCDEF123456789ABCDEF1, 16'h1234, 1'b0, N);
        check_tx(88'hABCDEF123456789ABCDEF1, 16'h1234, 1'b0, -1);
        idle_check(3);
        send_bits(88'hABCDEF123456789ABCDEF1, 16'h1234, 1'b1, N);
        check_tx(88'hABCDEF123456789ABCDEF1, 16'h1234, 1'b0, -1);

        // Random frames with gaps
        for (int r = 0; r < 3; r++) begin
            rand_frame(st, dy);
            send_bits(st, dy, 1'b1, N);
            check_tx(st, dy, 1'b0, -1);
        end
        idle_check(2);

        // Valid held through shift-out, then a normal frame
        rand_frame(st, dy);
        send_bits(st, dy, 1'b0, N);
        check_tx(st, dy, 1'b1, -1);
        rand_frame(st, dy);
        send_bits(st, dy, 1'b1, N);
        check_tx(st, dy, 1'b0, -1);
        idle_check(2);

        // Reset after 50 static bits, then all-zero static / all-one dynamic
        rand_frame(st, dy);
        send_bits(st, dy, 1'b0, 50);
        @(negedge CLK);
        check("partial_stat", {40'd0, STATLATCH}, {40'd0, exp_stat});
        check("partial_dyn", {112'd0, DYNLATCH}, {112'd0, exp_dyn});
        apply_reset();
        send_bits('0, 16'hFFFF, 1'b1, N);
        check_tx('0, 16'hFFFF, 1'b0, -1);
        idle_check(3);

        // Reset during dynamic shift-out cycle 5
        rand_frame(st, dy);
        send_bits(st, dy, 1'b0, N);
        check_tx(st, dy, 1'b0, S + 5);
        idle_check(5);

        // Back-to-back frames
        rand_frame(st, dy);
        rand_frame(st2, dy2);
        send_bits(st, dy, 1'b0, N);
        check_tx(st, dy, 1'b0, -1);
        send_bits(st2, dy2, 1'b0, N);
        check_tx(st2, dy2, 1'b0, -1);
        idle_check(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
